// File: rtl/offchip_line_burst_ctrl_if.sv
// Request/response and off-chip memory beat bus for the line burst controller.
// master: cache-side requester plus memory model; slave: the burst controller.
interface offchip_line_burst_ctrl_if #(
    parameter int LINE_BYTES = 16,
    parameter int MEM_DW     = 32,
    parameter int ADDR_W     = 32
);
    logic                      req_valid;
    logic                      req_ready;
    logic [1:0]                req_op;
    logic [ADDR_W-1:0]         req_addr;
    logic [ADDR_W-1:0]         req_wb_addr;
    logic [LINE_BYTES*8-1:0]   req_wdata;
    logic                      resp_valid;
    logic                      resp_err;
    logic [LINE_BYTES*8-1:0]   resp_rdata;
    logic [ADDR_W-1:0]         mem_addr;
    logic                      mem_re;
    logic                      mem_we;
    logic [MEM_DW-1:0]         mem_wdata;
    logic [MEM_DW/8-1:0]       mem_be;
    logic [MEM_DW-1:0]         mem_rdata;
    logic                      mem_ack;

    modport master (
        output req_valid, req_op, req_addr, req_wb_addr, req_wdata,
        output mem_rdata, mem_ack,
        input  req_ready, resp_valid, resp_err, resp_rdata,
        input  mem_addr, mem_re, mem_we, mem_wdata, mem_be
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wb_addr, req_wdata,
        input  mem_rdata, mem_ack,
        output req_ready, resp_valid, resp_err, resp_rdata,
        output mem_addr, mem_re, mem_we, mem_wdata, mem_be
    );
endinterface

// File: rtl/offchip_line_burst_ctrl.sv
// Cache line burst controller: moves one line to/from a narrower memory port as
// a sequence of acknowledged word beats, with optional writeback-then-refill
// and a per-beat acknowledge timeout.
module offchip_line_burst_ctrl #(
    parameter int LINE_BYTES  = 16,
    parameter int MEM_DW      = 32,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 1023
) (
    input logic clk,
    input logic rst,
    offchip_line_burst_ctrl_if.slave bus
);
    localparam int LINE_W = LINE_BYTES * 8;
    localparam int NBEATS = LINE_W / MEM_DW;
    localparam int BPB    = MEM_DW / 8;
    localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int WCW    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam bit TO_EN  = (TIMEOUT_CYC != 0);
    localparam logic [WCW-1:0] WAIT_LIMIT = TO_EN ? WCW'(TIMEOUT_CYC - 1) : '0;

    typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;

    state_t             state;
    logic [1:0]         op;
    logic [ADDR_W-1:0]  rd_base;
    logic [ADDR_W-1:0]  cur_base;
    logic [LINE_W-1:0]  wdata_r;
    logic [BW-1:0]      beat;
    logic [WCW-1:0]     wait_cnt;

    logic [BW-1:0]      nxt_beat;
    logic               last_beat;
    logic [ADDR_W-1:0]  nxt_addr;
    logic [MEM_DW-1:0]  nxt_wdata;
    logic               timed_out;

    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'(LINE_BYTES - 1);
    endfunction

    assign bus.mem_be = '1;

    // Next-beat address/data and end-of-beat conditions for the current phase
    always_comb begin
        nxt_beat  = beat + BW'(1);
        last_beat = (beat == BW'(NBEATS - 1));
        nxt_addr  = cur_base + ADDR_W'(int'(nxt_beat) * BPB);
        nxt_wdata = wdata_r[int'(nxt_beat) * MEM_DW +: MEM_DW];
        timed_out = TO_EN && (wait_cnt == WAIT_LIMIT);
    end

    // Transaction FSM with registered handshake, response and memory strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            op             <= '0;
            rd_base        <= '0;
            cur_base       <= '0;
            wdata_r        <= '0;
            beat           <= '0;
            wait_cnt       <= '0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= '0;
            bus.mem_re     <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        op            <= bus.req_op;
                        rd_base       <= line_base(bus.req_addr);
                        wdata_r       <= bus.req_wdata;
                        beat          <= '0;
                        wait_cnt      <= '0;
                        bus.req_ready <= 1'b0;
                        case (bus.req_op)
                            2'b00: begin
                                state        <= RD;
                                bus.mem_re   <= 1'b1;
                                cur_base     <= line_base(bus.req_addr);
                                bus.mem_addr <= line_base(bus.req_addr);
                            end
                            2'b01: begin
                                state         <= WR;
                                bus.mem_we    <= 1'b1;
                                cur_base      <= line_base(bus.req_addr);
                                bus.mem_addr  <= line_base(bus.req_addr);
                                bus.mem_wdata <= bus.req_wdata[MEM_DW-1:0];
                            end
                            2'b10: begin
                                state         <= WR;
                                bus.mem_we    <= 1'b1;
                                cur_base      <= line_base(bus.req_wb_addr);
                                bus.mem_addr  <= line_base(bus.req_wb_addr);
                                bus.mem_wdata <= bus.req_wdata[MEM_DW-1:0];
                            end
                            default: begin
                                state          <= DONE;
                                bus.resp_valid <= 1'b1;
                                bus.resp_err   <= 1'b1;
                            end
                        endcase
                    end
                end
                WR, RD: begin
                    if (bus.mem_ack) begin
                        wait_cnt <= '0;
                        if (state == RD) begin
                            bus.resp_rdata[int'(beat) * MEM_DW +: MEM_DW] <= bus.mem_rdata;
                        end
                        if (!last_beat) begin
                            beat          <= nxt_beat;
                            bus.mem_addr  <= nxt_addr;
                            bus.mem_wdata <= nxt_wdata;
                        end else if (state == WR && op == 2'b10) begin
                            // writeback done: swap strobes on the same edge so refill starts with no gap
                            state        <= RD;
                            beat         <= '0;
                            cur_base     <= rd_base;
                            bus.mem_addr <= rd_base;
                            bus.mem_we   <= 1'b0;
                            bus.mem_re   <= 1'b1;
                        end else begin
                            state          <= DONE;
                            bus.mem_we     <= 1'b0;
                            bus.mem_re     <= 1'b0;
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b0;
                        end
                    end else if (timed_out) begin
                        state          <= DONE;
                        bus.mem_we     <= 1'b0;
                        bus.mem_re     <= 1'b0;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b1;
                    end else if (TO_EN) begin
                        wait_cnt <= wait_cnt + WCW'(1);
                    end
                end
                DONE: begin
                    state          <= IDLE;
                    bus.resp_valid <= 1'b0;
                    bus.resp_err   <= 1'b0;
                    bus.req_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
